shift_arbiter: RTL and testbench

//   Shares a single Lshift32 barrel shifter between two requesters:

---
 rtl/shift_arbiter.sv | 170 +++++++++++++++++
 tb/tb_shift_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin share of one 32-bit left barrel shifter
// between the EX-stage ALU (port 0) and the multicycle/normalise unit (port 1).
// Ports:
//   clk, rst            clock, async active-high reset
//   reqN/opN/aN/shN     request + operands (op: 00 SLL, 01 SRL, 10 SRA, 11 ROL)
//   gntN                grant, operands captured on this edge
//   doneN/takeN         result valid for owner / owner accepts it
//   result              registered shift result
//   busy                arbiter not idle
module shift_arbiter #(
  parameter bit RR_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [1:0]  op0,
  input  logic [31:0] a0,
  input  logic [4:0]  sh0,
  output logic        gnt0,
  output logic        done0,
  input  logic        take0,
  input  logic        req1,
  input  logic [1:0]  op1,
  input  logic [31:0] a1,
  input  logic [4:0]  sh1,
  output logic        gnt1,
  output logic        done1,
  input  logic        take1,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    P1,
    P2,
    HOLD
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  function automatic logic [31:0] bitrev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [4:0]  sh_q, sh_d;
  logic        owner_q, owner_d;
  logic        pri_q, pri_d;
  logic [31:0] result_q, result_d;
  logic [31:0] part_q, part_d;

  logic [31:0] sh_in;
  logic [4:0]  sh_amt;
  logic [31:0] m;
  logic [31:0] m_rev;
  logic [31:0] sra_fill;
  logic        take_own;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_SLL;
      a_q      <= '0;
      sh_q     <= '0;
      owner_q  <= 1'b0;
      pri_q    <= RR_RESET;
      result_q <= '0;
      part_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      sh_q     <= sh_d;
      owner_q  <= owner_d;
      pri_q    <= pri_d;
      result_q <= result_d;
      part_q   <= part_d;
    end
  end

  // The one shared shifter. Right shifts and the wrap-around half of ROL
  // reverse the operand so a left shift does the work; P2 shifts by
  // (32 - sh) to produce the bits that wrap back in.
  always_comb begin
    sh_in  = a_q;
    sh_amt = sh_q;
    if (state_q == P2) begin
      sh_in  = bitrev(a_q);
      sh_amt = 5'd0 - sh_q;
    end else if (op_q == OP_SRL || op_q == OP_SRA) begin
      sh_in  = bitrev(a_q);
    end
    m        = sh_in << sh_amt;
    m_rev    = bitrev(m);
    sra_fill = a_q[31] ? ~(32'hFFFF_FFFF >> sh_q) : 32'h0;
  end

  always_comb begin
    gnt0 = (state_q == IDLE) && req0 && (!pri_q || !req1);
    gnt1 = (state_q == IDLE) && req1 && (pri_q || !req0);
  end

  assign take_own = owner_q ? take1 : take0;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    sh_d     = sh_q;
    owner_d  = owner_q;
    pri_d    = pri_q;
    result_d = result_q;
    part_d   = part_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          op_d    = gnt1 ? op1 : op0;
          a_d     = gnt1 ? a1 : a0;
          sh_d    = gnt1 ? sh1 : sh0;
          state_d = P1;
        end
      end
      P1: begin
        state_d = HOLD;
        unique case (op_q)
          OP_SLL: result_d = m;
          OP_SRL: result_d = m_rev;
          OP_SRA: result_d = m_rev | sra_fill;
          OP_ROL: begin
            if (sh_q == 5'd0) begin
              result_d = a_q;
            end else begin
              part_d  = m;
              state_d = P2;
            end
          end
          default: result_d = m;
        endcase
      end
      P2: begin
        result_d = part_q | m_rev;
        state_d  = HOLD;
      end
      HOLD: begin
        if (take_own) begin
          pri_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done0  = (state_q == HOLD) && !owner_q;
  assign done1  = (state_q == HOLD) && owner_q;
  assign result = result_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed scenarios for shift_arbiter
// covering shifts, rotate latency, round-robin, reset and take handling.
module tb_shift_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [1:0]  op0, op1;
  logic [31:0] a0, a1;
  logic [4:0]  sh0, sh1;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic        take0, take1;
  logic [31:0] result;
  logic        busy;

  int checks;
  int errors;

  shift_arbiter #(.RR_RESET(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .req0(req0),
    .op0(op0),
    .a0(a0),
    .sh0(sh0),
    .gnt0(gnt0),
    .done0(done0),
    .take0(take0),
    .req1(req1),
    .op1(op1),
    .a1(a1),
    .sh1(sh1),
    .gnt1(gnt1),
    .done1(done1),
    .take1(take1),
    .result(result),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive a request, wait for its grant, then count cycles to done.
  // lat = -1 when the grant or done never arrives.
  task automatic issue(input bit port, input logic [1:0] op,
                       input logic [31:0] a, input logic [4:0] sh,
                       output int lat, output logic [31:0] res);
    int w;
    @(negedge clk);
    if (port) begin
      req1 = 1'b1; op1 = op; a1 = a; sh1 = sh;
    end else begin
      req0 = 1'b1; op0 = op; a0 = a; sh0 = sh;
    end
    #1;
    w = 0;
    while (!(port ? gnt1 : gnt0) && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    lat = -1;
    res = 'x;
    if (w < 20) begin
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b0;
      lat = 0;
      w = 0;
      do begin
        @(negedge clk);
        lat++;
        w++;
      end while (!(port ? done1 : done0) && w < 20);
      if (w >= 20) lat = -1;
      res = result;
    end else begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  task automatic do_take(input bit port);
    @(negedge clk);
    if (port) take1 = 1'b1;
    else take0 = 1'b1;
    @(posedge clk);
    #1;
    take0 = 1'b0;
    take1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy} !== 5'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset: gnt=%b%b done=%b%b busy=%b result=%h exp all 0",
               gnt0, gnt1, done0, done1, busy, result);
    end
    do_reset();
  endtask

  task automatic test_sll();
    int lat;
    logic [31:0] res;
    issue(1'b0, 2'b00, 32'h0000_0001, 5'd31, lat, res);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL sll_lat: got %0d exp 2", lat);
    end
    checks++;
    if (res !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sll_res: got %h exp 80000000", res);
    end
    checks++;
    if (busy !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL sll_hold: busy=%b done1=%b exp 1 0", busy, done1);
    end
    do_take(1'b0);
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sll_take: done0=%b busy=%b exp 0 0", done0, busy);
    end
  endtask

  task automatic test_right();
    logic [1:0]  ops [5] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
    logic [31:0] as  [5] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                             32'h8000_0000, 32'h0000_00A5};
    logic [4:0]  shs [5] = '{5'd4, 5'd4, 5'd31, 5'd31, 5'd0};
    logic [31:0] exp [5] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0000,
                             32'hFFFF_FFFF, 32'h0000_00A5};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, ops[i], as[i], shs[i], lat, res);
      checks++;
      if (lat !== 2 || res !== exp[i]) begin
        errors++;
        $display("FAIL right_%0d: lat=%0d res=%h exp lat 2 res %h",
                 i, lat, res, exp[i]);
      end
      do_take(1'b1);
    end
  endtask

  task automatic test_rol();
    logic [31:0] as  [4] = '{32'h8000_0001, 32'h8000_0001, 32'h1234_5678,
                             32'h0000_0001};
    logic [4:0]  shs [4] = '{5'd1, 5'd0, 5'd16, 5'd31};
    logic [31:0] exp [4] = '{32'h0000_0003, 32'h8000_0001, 32'h5678_1234,
                             32'h8000_0000};
    int          elat [4] = '{3, 2, 3, 3};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 2'b11, as[i], shs[i], lat, res);
      checks++;
      if (lat !== elat[i] || res !== exp[i]) begin
        errors++;
        $display("FAIL rol_%0d: lat=%0d res=%h exp lat %0d res %h",
                 i, lat, res, elat[i], exp[i]);
      end
      do_take(1'b0);
    end
  endtask

  task automatic test_round_robin();
    int w;
    bit who;
    do_reset();
    @(negedge clk);
    req0 = 1'b1; op0 = 2'b00; a0 = 32'h1; sh0 = 5'd0;
    req1 = 1'b1; op1 = 2'b00; a1 = 32'h2; sh1 = 5'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      w = 0;
      while (!(gnt0 || gnt1) && w < 20) begin
        @(negedge clk);
        #1;
        w++;
      end
      who = gnt1;
      checks++;
      if (w >= 20 || (gnt0 && gnt1) || who !== k[0]) begin
        errors++;
        $display("FAIL rr_grant_%0d: gnt0=%b gnt1=%b exp port %0d",
                 k, gnt0, gnt1, k[0]);
      end
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!(who ? done1 : done0) && w < 20);
      checks++;
      if (w >= 20 || result !== (who ? 32'h2 : 32'h1)) begin
        errors++;
        $display("FAIL rr_res_%0d: result=%h exp %h",
                 k, result, who ? 32'h2 : 32'h1);
      end
      if (k == 0) begin
        for (int d = 0; d < 5; d++) begin
          @(negedge clk);
          checks++;
          if (done0 !== 1'b1 || result !== 32'h1 || gnt0 || gnt1) begin
            errors++;
            $display("FAIL rr_stall_%0d: done0=%b result=%h gnt=%b%b exp 1 1 00",
                     d, done0, result, gnt0, gnt1);
          end
        end
      end
      do_take(who);
      @(negedge clk);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    do_take(1'b0);
    do_take(1'b1);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] res;
    @(negedge clk);
    req0 = 1'b1; op0 = 2'b11; a0 = 32'h8000_0001; sh0 = 5'd1;
    #1;
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_gnt: gnt0=%b exp 1", gnt0);
    end
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done0 !== 1'b0 || result !== 32'h0 || gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: busy=%b done0=%b result=%h gnt0=%b exp 0",
               busy, done0, result, gnt0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_nodone_%0d: done=%b%b busy=%b exp 0",
                 i, done0, done1, busy);
      end
    end
    issue(1'b0, 2'b00, 32'h0000_0003, 5'd2, lat, res);
    checks++;
    if (lat !== 2 || res !== 32'h0000_000C) begin
      errors++;
      $display("FAIL rstmid_next: lat=%0d res=%h exp lat 2 res 0000000c",
               lat, res);
    end
    do_take(1'b0);
  endtask

  task automatic test_take_nonowner();
    int lat;
    logic [31:0] res;
    issue(1'b0, 2'b00, 32'h0000_0005, 5'd1, lat, res);
    checks++;
    if (lat !== 2 || res !== 32'h0000_000A) begin
      errors++;
      $display("FAIL nonown_res: lat=%0d res=%h exp lat 2 res 0000000a",
               lat, res);
    end
    do_take(1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (done0 !== 1'b1 || busy !== 1'b1 || result !== 32'h0000_000A) begin
        errors++;
        $display("FAIL nonown_hold_%0d: done0=%b busy=%b result=%h exp 1 1 0000000a",
                 i, done0, busy, result);
      end
    end
    do_take(1'b0);
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nonown_take: done0=%b busy=%b exp 0 0", done0, busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req0 = 1'b0; op0 = 2'b00; a0 = '0; sh0 = '0; take0 = 1'b0;
    req1 = 1'b0; op1 = 2'b00; a1 = '0; sh1 = '0; take1 = 1'b0;
    test_reset();
    test_sll();
    test_right();
    test_rol();
    test_round_robin();
    test_reset_mid();
    test_take_nonowner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
